erasable_core_responder: RTL
============================

// Module: erasable_core_responder
// PURPOSE
//  Erasable (core) memory responder: the far end of the parity/S-register
//  interface. It accepts a memory-cycle request carrying the S address and
//  EB bank. It performs a destructive read and returns the 15-bit word plus
//  stored parity for the G register, flagging odd-parity failures.
//  It then restores the word, or writes the new word and parity the initiator
//  supplies inside the write-back window. Sits between the S/G/parity logic
//  and a 2048x16 erasable array.
// PARAMETERS
//  WB_DLY       4   write-back window length in clocks after strobe (>=1)
//  INIT_PARITY  1   parity bit of every word at simulation start (data = 0)
// PORTS
//  clk        in   1   single system clock
//  rst        in   1   asynchronous reset, active-low
//  req        in   1   memory-cycle request, sampled on the rising edge
//  s_addr     in   12  S register bits S12..S01
//  eb         in   3   erasable bank EB11..EB9, sampled with req
//  wr_en      in   1   write-back load strobe, valid only in the window
//  wr_data    in   15  word to write (G15..G01)
//  wr_par     in   1   parity bit to write, generated by the initiator
//  rd_data    out  15  sensed word
//  rd_par     out  1   sensed parity bit
//  rd_valid   out  1   one-clock strobe: rd_data/rd_par/par_err valid
//  par_err    out  1   odd-parity failure on the sensed word, {rd_par,rd_data}
//  busy       out  1   cycle in progress; req ignored while high
//  req_drop   out  1   one-clock pulse: req arrived while busy
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all outputs 0; sense reg and window
//    counter cleared. The array is NOT reset.
//  - Decode: erasable iff s_addr[11:10]==2'b00; otherwise req is ignored
//    (fixed memory): busy stays 0 and req_drop stays 0.
//  - Bank: s_addr[9:8]==2'b11 -> bank=eb; else bank={1'b0,s_addr[9:8]}.
//  - Array index = {bank,s_addr[7:0]}, 11 bits. Index and bank latch at
//    acceptance; eb/s_addr changes mid-cycle have no effect.
//  - FSM: IDLE -> SENSE -> STROBE -> WINDOW -> RESTORE -> IDLE.
//  - Edge k: req accepted in IDLE; busy=1 from k+1.
//  - SENSE (cycle k+1): the array word goes to the sense reg, and the
//    location is written with 16'h0000 (destructive read).
//  - STROBE (k+2): rd_valid=1 for exactly one clock. rd_data/rd_par show the
//    sense reg. par_err = ~^{rd_par,rd_data} (1 = even count, an error).
//    rd_data/rd_par hold until the next STROBE; par_err/rd_valid drop after.
//  - WINDOW (k+3 .. k+2+WB_DLY): wr_en=1 loads wr_data/wr_par into the sense
//    reg. The last wr_en wins. wr_en outside WINDOW is ignored.
//  - RESTORE (k+3+WB_DLY): the sense reg is written to the array. busy drops
//    on the following edge. Total cycle = WB_DLY+3 clocks after acceptance.
//  - Back-to-back: req is accepted in the IDLE cycle right after RESTORE.
//  - req while busy: dropped, never queued; req_drop=1 for that clock.
//  - The responder never computes write parity. An initiator-supplied bad
//    parity is stored and detected on the next read.
//  - Reset mid-cycle: FSM to IDLE, with no write-back. If reset hits after
//    SENSE, the location stays zeroed. Its next read gives data 0, parity 0,
//    par_err=1 (required, models lost core restore).
//  - Simulation init: every word is {INIT_PARITY, 15'h0}.
// STRUCTURE
//  - Shared package agc_mem_pkg: state enum, ERASABLE_WORDS=2048,
//    function erasable_index(s_addr, eb), function odd_par_ok(word16).
//  - One sub-module, erasable_core_array: 2048x16 synchronous
//    single-port RAM with a read-then-clear port used in SENSE.
//  - FSM, window counter, sense reg and decode stay in this module.
// TESTING
//  1 Write/read: cycle at s_addr=12'o0100, wr_en with wr_data=15'o12345,
//    wr_par=1 in the window. A second read at 12'o0100 gives rd_data=15'o12345,
//    rd_par=1, par_err=0, with rd_valid two clocks after req.
//  2 Banking: write 15'o00007 at s_addr=12'o1400 with eb=3'd5, and 15'o00003
//    with eb=3'd2. Reading with eb=5 gives 15'o00007; reading s_addr=12'o1000
//    (bank 2, offset 0) gives 15'o00003.
//  3 Restore: read without wr_en at the case-1 location, then read again. Both
//    give 15'o12345/par 1; the array is zero only during the SENSE..RESTORE span.
//  4 Parity: write 15'o00001 with wr_par=1 (even count). The next read gives
//    par_err=1. After init, reading any location gives data 0, par 1, par_err=0.
//  5 Protocol: req at s_addr=12'o2000 gives busy=0. A second req at k+2 gives
//    req_drop=1 at that clock and is not serviced. A req right after RESTORE
//    is accepted.
//  6 Reset at k+2: assert rst low. Then busy=0 and all outputs 0; the location
//    reads 0, par 0, par_err=1. wr_en at k+1 (pre-window) is ignored.

Source files
------------

// File: rtl/agc_mem_pkg.sv
// Shared types and helpers for the erasable core memory responder.
package agc_mem_pkg;

    localparam int unsigned ERASABLE_WORDS = 2048;
    localparam int unsigned IDX_W          = 11;

    typedef enum logic [2:0] {
        StIdle,
        StSense,
        StStrobe,
        StWindow,
        StRestore
    } state_t;

    // Erasable space is the bottom quarter of S; everything else is fixed memory.
    function automatic logic is_erasable(input logic [11:0] s_addr);
        return s_addr[11:10] == 2'b00;
    endfunction

    // S09..S08 == 11 selects the switched bank from EB; otherwise the fixed banks 0..2.
    function automatic logic [IDX_W-1:0] erasable_index(input logic [11:0] s_addr,
                                                        input logic [2:0]  eb);
        logic [2:0] bank;
        bank = (s_addr[9:8] == 2'b11) ? eb : {1'b0, s_addr[9:8]};
        return {bank, s_addr[7:0]};
    endfunction

    // Odd parity over {parity, data} is the valid encoding.
    function automatic logic odd_par_ok(input logic [15:0] word16);
        return ^word16;
    endfunction

endpackage

// File: rtl/erasable_core_array.sv
// 2048x16 erasable core array: combinational sense, synchronous clear or write.
module erasable_core_array
    import agc_mem_pkg::*;
#(
    parameter bit INIT_PARITY = 1'b1
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic             rd_clr,
    input  logic             wr_en,
    input  logic [15:0]      wr_data,
    output logic [15:0]      rd_data
);

    // Words are stored XORed with Bias so an all-zero power-up image reads back
    // as {INIT_PARITY, 15'h0} without any reset or preload of the array.
    localparam logic [15:0] Bias = {INIT_PARITY, 15'h0000};

    logic [15:0] mem [ERASABLE_WORDS];

    assign rd_data = mem[addr] ^ Bias;

    // Read-then-clear: the sensed word is taken combinationally and the core is zeroed.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            mem[addr] <= Bias;
        end else if (wr_en) begin
            mem[addr] <= wr_data ^ Bias;
        end
    end

endmodule

// File: rtl/erasable_core_responder.sv
// Erasable core memory responder: destructive read, parity check, write-back window.
module erasable_core_responder
    import agc_mem_pkg::*;
#(
    parameter int unsigned WB_DLY      = 4,
    parameter bit          INIT_PARITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [11:0] s_addr,
    input  logic [2:0]  eb,
    input  logic        wr_en,
    input  logic [14:0] wr_data,
    input  logic        wr_par,
    output logic [14:0] rd_data,
    output logic        rd_par,
    output logic        rd_valid,
    output logic        par_err,
    output logic        busy,
    output logic        req_drop
);

    localparam int unsigned CntW = (WB_DLY > 1) ? $clog2(WB_DLY) : 1;

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic [15:0]      sense_q;
    logic [CntW-1:0]  win_cnt;
    logic [15:0]      arr_word;

    erasable_core_array #(
        .INIT_PARITY(INIT_PARITY)
    ) u_array (
        .clk     (clk),
        .addr    (idx_q),
        .rd_clr  (state == StSense),
        .wr_en   (state == StRestore),
        .wr_data (sense_q),
        .rd_data (arr_word)
    );

    // Memory-cycle sequencer with registered outputs; reset abandons any write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            idx_q    <= '0;
            sense_q  <= '0;
            win_cnt  <= '0;
            rd_data  <= '0;
            rd_par   <= 1'b0;
            rd_valid <= 1'b0;
            par_err  <= 1'b0;
            busy     <= 1'b0;
            req_drop <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            par_err  <= 1'b0;
            req_drop <= req && (state != StIdle);
            unique case (state)
                StIdle: begin
                    if (req && is_erasable(s_addr)) begin
                        idx_q <= erasable_index(s_addr, eb);
                        busy  <= 1'b1;
                        state <= StSense;
                    end
                end
                StSense: begin
                    sense_q  <= arr_word;
                    rd_data  <= arr_word[14:0];
                    rd_par   <= arr_word[15];
                    rd_valid <= 1'b1;
                    par_err  <= ~odd_par_ok(arr_word);
                    state    <= StStrobe;
                end
                StStrobe: begin
                    win_cnt <= CntW'(WB_DLY - 1);
                    state   <= StWindow;
                end
                StWindow: begin
                    if (wr_en) begin
                        sense_q <= {wr_par, wr_data};
                    end
                    if (win_cnt == '0) begin
                        state <= StRestore;
                    end else begin
                        win_cnt <= win_cnt - 1'b1;
                    end
                end
                StRestore: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
